// File: rtl/add_inv_pipe.sv
// ---------------------------------------------------------------------------
// add_inv_pipe
//   Multi-lane add / invert datapath in a 2-stage registered pipeline with
//   valid/ready flow control. Each lane combines A and B according to the
//   per-beat mode. Lanes are independent; no carry crosses a lane boundary.
//
//   Modes: 0 ADD    r = a+b            (SAT: clamp to all-ones on carry)
//          1 ADDINV r = a + ~(a+b)     (equals ~b, carry out reported)
//          2 SUB    r = a-b            (SAT: clamp to zero on borrow)
//          3 INV    r = ~a, carry 0
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready
//   mode       per-beat operation select
//   a, b       packed operands, lane 0 in the LSBs
//   out_valid  result beat valid
//   out_ready  consumer takes beat when out_valid & out_ready
//   z          packed result
//   carry      per-lane carry / borrow flag
// ---------------------------------------------------------------------------
module add_inv_pipe #(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    parameter int SAT   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] z,
    output logic [LANES-1:0]       carry
);

    localparam logic [1:0] MODE_ADD    = 2'd0;
    localparam logic [1:0] MODE_ADDINV = 2'd1;
    localparam logic [1:0] MODE_SUB    = 2'd2;
    localparam logic [1:0] MODE_INV    = 2'd3;

    localparam int SW = WIDTH + 1;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] r, input logic c);
        return ((SAT != 0) && c) ? {WIDTH{1'b1}} : r;
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] r, input logic c);
        return ((SAT != 0) && c) ? {WIDTH{1'b0}} : r;
    endfunction

    logic [LANES*SW-1:0]    w_sum_p0;
    logic [LANES*WIDTH-1:0] w_z_p1;
    logic [LANES-1:0]       w_c_p1;
    logic                   w_s1_adv;
    logic                   w_s2_adv;

    logic [LANES*WIDTH-1:0] r_a_p1;
    logic [LANES*SW-1:0]    r_s_p1;
    logic [1:0]             r_mode_p1;
    logic                   r_vld_p1;

    logic [LANES*WIDTH-1:0] r_z_p2;
    logic [LANES-1:0]       r_c_p2;
    logic                   r_vld_p2;

    // A stage may load when it is empty or its contents move on this edge.
    assign w_s2_adv = !r_vld_p2 || out_ready;
    assign w_s1_adv = !r_vld_p1 || w_s2_adv;
    assign in_ready = w_s1_adv;

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            logic [WIDTH-1:0] w_a;
            logic [WIDTH-1:0] w_sl;
            logic [WIDTH-1:0] w_b;
            logic [SW-1:0]    w_s;
            logic [WIDTH-1:0] w_r;
            logic             w_c;

            // ---- stage 0 -> 1 : full-width lane sum ----
            assign w_sum_p0[l*SW +: SW] = {1'b0, a[l*WIDTH +: WIDTH]} + {1'b0, b[l*WIDTH +: WIDTH]};

            // ---- stage 1 -> 2 : mode-dependent result ----
            assign w_a  = r_a_p1[l*WIDTH +: WIDTH];
            assign w_s  = r_s_p1[l*SW +: SW];
            assign w_sl = w_s[WIDTH-1:0];
            // b is not stored; it is recovered exactly from the wrapped sum.
            assign w_b  = w_sl - w_a;

            always_comb begin
                w_r = '0;
                w_c = 1'b0;
                unique case (r_mode_p1)
                    MODE_ADD: begin
                        w_c = w_s[WIDTH];
                        w_r = sat_add(w_sl, w_s[WIDTH]);
                    end
                    MODE_ADDINV: begin
                        {w_c, w_r} = {1'b0, w_a} + {1'b0, ~w_sl};
                    end
                    MODE_SUB: begin
                        w_c = (w_a < w_b);
                        w_r = sat_sub(w_a - w_b, w_a < w_b);
                    end
                    MODE_INV: begin
                        w_r = ~w_a;
                        w_c = 1'b0;
                    end
                    default: begin
                        w_r = '0;
                        w_c = 1'b0;
                    end
                endcase
            end

            assign w_z_p1[l*WIDTH +: WIDTH] = w_r;
            assign w_c_p1[l]                = w_c;
        end
    endgenerate

    // ---- stage 1 register: operand capture ----
    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_a_p1    <= a;
            r_s_p1    <= w_sum_p0;
            r_mode_p1 <= mode;
        end
    end

    // ---- stage 1 valid and stage 2 output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_z_p2   <= '0;
            r_c_p2   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_vld_p1 <= in_valid;
            end
            if (w_s2_adv) begin
                r_vld_p2 <= r_vld_p1;
                // A bubble clears out_valid but leaves the last result visible.
                if (r_vld_p1) begin
                    r_z_p2 <= w_z_p1;
                    r_c_p2 <= w_c_p1;
                end
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign z         = r_z_p2;
    assign carry     = r_c_p2;

endmodule
